// File: rtl/uart_byte_rx_if.sv
// Received-byte output group of uart_byte_rx: byte, valid/frame-error strobes, busy.
interface uart_byte_rx_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    modport master (output o_data, o_valid, o_frame_err, o_busy);
    modport slave  (input  o_data, o_valid, o_frame_err, o_busy);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 2-FF input synchroniser and one-cycle byte/frame-error strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each decision edge.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_rx,
    uart_byte_rx_if.master rx_out
);

    localparam int N  = CLK_FREQ / BAUD;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);

    if (N < 8) begin : g_n_check
        $error("uart_byte_rx: CLK_FREQ/BAUD must be at least 8");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitn_q, bitn_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          s1, s2;
    logic          smp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= i_rx;
            s2 <= s1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Free-running history: at a decision edge it holds s2 from the two preceding edges.
    logic [1:0] hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) hist <= '1;
        else       hist <= {hist[0], s2};
    end

    assign smp = (hist[1] & hist[0]) | (hist[1] & s2) | (hist[0] & s2);
`else
    assign smp = s2;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bitn_d  = bitn_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!s2) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (smp) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bitn_d  = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    sh_d   = {smp, sh_q[7:1]};
                    bitn_d = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (smp) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end
            BRK: begin
                // A held-low line must rise before a new start edge is looked for.
                cnt_d = '0;
                if (s2) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_out.o_data      = data_q;
    assign rx_out.o_valid     = valid_q;
    assign rx_out.o_frame_err = ferr_q;
    assign rx_out.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at N=16: event-queue model of expected strobes plus literal pins.
module tb_uart_byte_rx;

    localparam int N   = 16;
    localparam int H   = 8;
    localparam int FRM = 10 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    always #5 clk = ~clk;

    uart_byte_rx_if bus ();

    uart_byte_rx #(
        .CLK_FREQ(1_600_000),
        .BAUD    (100_000)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_rx  (rx),
        .rx_out(bus)
    );

    typedef struct {
        int         edge_n;
        bit         ferr;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] model_data = 8'h00;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         last_ferr_cyc = 0;
    int         vcyc[$];
    logic [7:0] vdat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: each fully sent frame owes exactly one strobe, 2+H+9N edges after its edge 0.
    initial begin
        logic exp_v, exp_f;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                model_data = 8'h00;
                evq.delete();
                check("rst_data",  bus.o_data,      8'h00);
                check("rst_valid", bus.o_valid,     1'b0);
                check("rst_ferr",  bus.o_frame_err, 1'b0);
                check("rst_busy",  bus.o_busy,      1'b0);
            end else begin
                exp_v = 1'b0;
                exp_f = 1'b0;
                if (evq.size() > 0 && evq[0].edge_n == cyc) begin
                    if (evq[0].ferr) begin
                        exp_f = 1'b1;
                    end else begin
                        exp_v      = 1'b1;
                        model_data = evq[0].data;
                    end
                    void'(evq.pop_front());
                end
                check("valid", bus.o_valid,     exp_v);
                check("ferr",  bus.o_frame_err, exp_f);
                check("data",  bus.o_data,      model_data);
                check("excl",  bus.o_valid & bus.o_frame_err, 1'b0);
                if (bus.o_valid === 1'b1) begin
                    valid_cnt++;
                    vcyc.push_back(cyc);
                    vdat.push_back(bus.o_data);
                end
                if (bus.o_frame_err === 1'b1) begin
                    ferr_cnt++;
                    last_ferr_cyc = cyc;
                end
            end
        end
    end

    // Called at a negedge; cycle i of the frame is captured into s1 at edge e0+i.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int glitch,
                              input logic [7:0] expd, input int ncyc, output int e0);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        e0 = cyc + 1;
        if (ncyc == FRM) evq.push_back('{e0 + 2 + H + 9 * N, !stop, expd});
        for (int i = 0; i < ncyc; i++) begin
            rx = fr[i / N] ^ (i == glitch);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int e0, e1, v0, f0;
        logic [7:0] glitch_exp;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(5);

        // Single byte with ideal timing
        v0 = valid_cnt;
        send_frame(8'h55, 1'b1, -1, 8'h55, FRM, e0);
        check("t1_busy_after", bus.o_busy, 1'b0);
        check("t1_count", valid_cnt - v0, 1);
        check("t1_latency", vcyc[vcyc.size() - 1] - e0, 154);
        check("t1_data", vdat[vdat.size() - 1], 8'h55);
        check("t1_no_ferr", ferr_cnt, 0);

        // Back-to-back frames, no idle gap
        idle(3);
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b1, -1, 8'hA5, FRM, e0);
        send_frame(8'h3C, 1'b1, -1, 8'h3C, FRM, e1);
        idle(4);
        check("t2_count", valid_cnt - v0, 2);
        check("t2_gap", vcyc[vcyc.size() - 1] - vcyc[vcyc.size() - 2], 160);
        check("t2_first", vdat[vdat.size() - 2], 8'hA5);
        check("t2_second", vdat[vdat.size() - 1], 8'h3C);

        // Framing error followed by a 40 bit-time break
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'hFF, 1'b0, -1, 8'h00, FRM, e0);
        repeat (40 * N) @(negedge clk);
        check("t3_ferr_count", ferr_cnt - f0, 1);
        check("t3_ferr_latency", last_ferr_cyc - e0, 154);
        check("t3_no_valid", valid_cnt - v0, 0);
        check("t3_busy_break", bus.o_busy, 1'b1);
        check("t3_data_held", bus.o_data, 8'h3C);
        rx = 1'b1;
        @(negedge clk);
        check("t3_busy_rise0", bus.o_busy, 1'b1);
        @(negedge clk);
        check("t3_busy_rise1", bus.o_busy, 1'b1);
        @(negedge clk);
        check("t3_busy_rise2", bus.o_busy, 1'b0);
        idle(20);
        send_frame(8'h12, 1'b1, -1, 8'h12, FRM, e0);
        check("t3_next_data", bus.o_data, 8'h12);

        // Start glitch shorter than half a bit
        idle(10);
        v0 = valid_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 16; i++) begin
            rx = (i < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (i == 2)     check("t4_busy_rise", bus.o_busy, 1'b1);
            if (i == H + 1) check("t4_busy_hold", bus.o_busy, 1'b1);
            if (i == H + 2) check("t4_busy_fall", bus.o_busy, 1'b0);
        end
        check("t4_no_strobe", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        send_frame(8'h81, 1'b1, -1, 8'h81, FRM, e0);
        check("t4_next_data", vdat[vdat.size() - 1], 8'h81);

        // Reset in data bit 3; the transmitter shares the reset and releases the line
        idle(10);
        v0 = valid_cnt;
        send_frame(8'hC3, 1'b1, -1, 8'h00, 4 * N + 8, e0);
        check("t5_busy_pre", bus.o_busy, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy_rst", bus.o_busy, 1'b0);
        check("t5_data_rst", bus.o_data, 8'h00);
        idle(32);
        check("t5_no_strobe", valid_cnt - v0, 0);
        send_frame(8'h7E, 1'b1, -1, 8'h7E, FRM, e0);
        check("t5_next_data", vdat[vdat.size() - 1], 8'h7E);

        // One-cycle high glitch captured exactly for the data bit 2 decision
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h04;
`endif
        idle(10);
        send_frame(8'h00, 1'b1, 2 + H + 3 * N - 2 - 8 + 8, glitch_exp, FRM, e0);
        check("t6_data", vdat[vdat.size() - 1], glitch_exp);

        idle(10);
        check("queue_drained", evq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
